// File: rtl/rvv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvv_pkg
// Brief    : Shared RVV types for the vector configuration unit: vtype
//            layout, vset* operation encoding, decoded request record and
//            the VLMAX exponent helper.
// Revision : 1.0
// ============================================================================
package rvv_pkg;

  // Widest scalar register the request record can carry.
  localparam int XlenMax = 64;

  localparam logic [6:0] OpcodeVec = 7'b1010111;
  localparam logic [2:0] OPCFG     = 3'b111;

  // All eight encodings are named so raw vtype bits always cast cleanly.
  typedef enum logic [2:0] {
    EW8      = 3'd0,
    EW16     = 3'd1,
    EW32     = 3'd2,
    EW64     = 3'd3,
    EW_RSVD4 = 3'd4,
    EW_RSVD5 = 3'd5,
    EW_RSVD6 = 3'd6,
    EW_RSVD7 = 3'd7
  } vew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_1_8  = 3'd5,
    LMUL_1_4  = 3'd6,
    LMUL_1_2  = 3'd7
  } vlmul_e;

  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } vtype_t;

  typedef enum logic [1:0] {
    VSETVLI  = 2'd0,
    VSETIVLI = 2'd1,
    VSETVL   = 2'd2
  } vcfg_op_e;

  // Decoded vset* request; vtype holds zimm (zero-extended) or rs2.
  typedef struct packed {
    vcfg_op_e             op;
    logic [4:0]           rd;
    logic [4:0]           rs1_idx;
    logic [XlenMax-1:0]   vtype;
    logic [XlenMax-1:0]   avl;
  } vcfg_req_t;

  localparam vtype_t VtypeResetVal = '{vill: 1'b1, vma: 1'b0, vta: 1'b0,
                                       vsew: EW8, vlmul: LMUL_1};

  // log2(VLMAX) = log2(VLEN) - 3 - vsew + signed(vlmul); may go negative
  // for illegal combinations, which callers must screen out.
  function automatic int vlmax_log2(vew_e sew, vlmul_e lmul, int vlen);
    int vlen_lg;
    int lmul_s;
    vlen_lg = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < vlen) vlen_lg = i + 1;
    end
    lmul_s = int'(lmul);
    if (lmul_s >= 4) lmul_s = lmul_s - 8;
    return vlen_lg - 3 - int'(sew) + lmul_s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vcfg_unit_vlmax.sv
`default_nettype none
// ============================================================================
// Module   : vcfg_unit_vlmax
// Brief    : Combinational vtype legality check and VLMAX computation for a
//            candidate SEW/LMUL pair.
// Revision : 1.0
// ============================================================================
module vcfg_unit_vlmax
  import rvv_pkg::*;
#(
  parameter int VLEN    = 128,
  parameter int ELEN    = 64,
  parameter int VLWIDTH = $clog2(VLEN) + 1
) (
  input  vew_e               sew,
  input  vlmul_e             lmul,
  output logic               legal,
  output logic [VLWIDTH-1:0] vlmax
);

  localparam int ElenLg = $clog2(ELEN);

  int sew_lg;
  int lmul_i;
  int lg;

  // Legality screens reserved LMUL, SEW beyond ELEN and SEW > LMUL*ELEN.
  always_comb begin
    legal  = 1'b1;
    vlmax  = '0;
    sew_lg = 3 + int'(sew);
    lmul_i = int'(lmul);
    lg     = vlmax_log2(sew, lmul, VLEN);
    if (lmul == LMUL_RSVD) legal = 1'b0;
    if (sew_lg > ElenLg) legal = 1'b0;
    if (lmul_i >= 5 && sew_lg > ElenLg - (8 - lmul_i)) legal = 1'b0;
    if (legal && lg >= 0 && lg < VLWIDTH) vlmax = VLWIDTH'(1) << lg;
  end

endmodule
`default_nettype wire

// File: rtl/vcfg_unit.sv
`default_nettype none
// ============================================================================
// Module   : vcfg_unit
// Brief    : Executes vsetvli / vsetivli / vsetvl and owns the architectural
//            vtype and vl seen by the vector pipeline. Three-state flow:
//            IDLE (accept) -> CALC (compute, commit) -> RESP (hold response).
// Revision : 1.0
// ============================================================================
module vcfg_unit
  import rvv_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 64,
  parameter int XLEN = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    insn_valid_i,
  output logic                    insn_ready_o,
  input  logic [31:0]             insn_i,
  input  logic [XLEN-1:0]         rs1_i,
  input  logic [XLEN-1:0]         rs2_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [4:0]              resp_rd_o,
  output logic [XLEN-1:0]         resp_vl_o,
  output logic                    resp_illegal_o,
  output vtype_t                  vtype_o,
  output logic [$clog2(VLEN):0]   vl_o
);

  localparam int VLWidth = $clog2(VLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 accept;

  vcfg_req_t            dec_req;
  logic                 dec_illegal;
  vcfg_req_t            req_q;
  logic                 req_illegal_q;

  vtype_t               vtype_q, vtype_d;
  logic [VLWidth-1:0]   vl_q, vl_d;
  logic [4:0]           rd_q, rd_d;
  logic [XLEN-1:0]      resp_vl_q, resp_vl_d;
  logic                 ill_q, ill_d;

  vew_e                 cand_sew;
  vlmul_e               cand_lmul;
  logic                 cand_legal;
  logic [VLWidth-1:0]   cand_vlmax;
  logic                 rsvd_bad;
  logic                 avl_path;
  logic [VLWidth-1:0]   new_vl;
  logic                 go_vill;

  assign accept         = insn_valid_i && insn_ready_o;
  assign resp_valid_o   = (state_q == RESP);
  assign resp_rd_o      = rd_q;
  assign resp_vl_o      = resp_vl_q;
  assign resp_illegal_o = ill_q;
  assign vtype_o        = vtype_q;
  assign vl_o           = vl_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and ready; RESP passes ready straight through from the consumer.
  always_comb begin
    state_d      = state_q;
    insn_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        insn_ready_o = 1'b1;
        if (insn_valid_i) state_d = CALC;
      end
      CALC: state_d = RESP;
      RESP: begin
        insn_ready_o = resp_ready_i;
        if (resp_ready_i) state_d = insn_valid_i ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the incoming instruction into a request record.
  always_comb begin
    dec_req         = '0;
    dec_illegal     = 1'b1;
    dec_req.op      = VSETVLI;
    dec_req.rd      = insn_i[11:7];
    dec_req.rs1_idx = insn_i[19:15];
    dec_req.avl     = XlenMax'(rs1_i);
    if (insn_i[6:0] == OpcodeVec && insn_i[14:12] == OPCFG) begin
      if (!insn_i[31]) begin
        dec_illegal   = 1'b0;
        dec_req.op    = VSETVLI;
        dec_req.vtype = XlenMax'(insn_i[30:20]);
      end else if (insn_i[30]) begin
        dec_illegal   = 1'b0;
        dec_req.op    = VSETIVLI;
        dec_req.vtype = XlenMax'(insn_i[29:20]);
        dec_req.avl   = XlenMax'(insn_i[19:15]);
      end else if (insn_i[31:25] == 7'b1000000) begin
        dec_illegal   = 1'b0;
        dec_req.op    = VSETVL;
        dec_req.vtype = XlenMax'(rs2_i);
      end
    end
  end

  // Latch the decoded request when an instruction is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q         <= '0;
      req_illegal_q <= 1'b0;
    end else if (accept) begin
      req_q         <= dec_req;
      req_illegal_q <= dec_illegal;
    end
  end

  assign cand_sew  = vew_e'(req_q.vtype[5:3]);
  assign cand_lmul = vlmul_e'(req_q.vtype[2:0]);

  vcfg_unit_vlmax #(
    .VLEN    (VLEN),
    .ELEN    (ELEN),
    .VLWIDTH (VLWidth)
  ) u_vlmax (
    .sew   (cand_sew),
    .lmul  (cand_lmul),
    .legal (cand_legal),
    .vlmax (cand_vlmax)
  );

  // vsetivli only has the 10-bit zimm; the other forms reject any set bit
  // above vma, including the top (vill) bit of rs2.
  assign rsvd_bad = (req_q.op != VSETIVLI) && (|req_q.vtype[XlenMax-1:8]);
  assign avl_path = (req_q.rs1_idx != 5'd0) || (req_q.op == VSETIVLI);

  // New vl selection and vill decision for the latched request.
  always_comb begin
    new_vl  = vl_q;
    go_vill = !cand_legal || rsvd_bad;
    if (avl_path) begin
      if (req_q.avl[XLEN-1:0] < XLEN'(cand_vlmax)) new_vl = req_q.avl[VLWidth-1:0];
      else                                         new_vl = cand_vlmax;
    end else if (req_q.rd != 5'd0) begin
      new_vl = cand_vlmax;
    end else if (vtype_q.vill || vl_q > cand_vlmax) begin
      go_vill = 1'b1;
    end
  end

  // Architectural state and response updates, applied only leaving CALC.
  always_comb begin
    vtype_d   = vtype_q;
    vl_d      = vl_q;
    rd_d      = rd_q;
    resp_vl_d = resp_vl_q;
    ill_d     = ill_q;
    if (state_q == CALC) begin
      if (req_illegal_q) begin
        ill_d     = 1'b1;
        rd_d      = 5'd0;
        resp_vl_d = '0;
      end else begin
        ill_d = 1'b0;
        rd_d  = req_q.rd;
        if (go_vill) begin
          vtype_d   = VtypeResetVal;
          vl_d      = '0;
          resp_vl_d = '0;
        end else begin
          vtype_d = '{vill: 1'b0, vma: req_q.vtype[7], vta: req_q.vtype[6],
                      vsew: cand_sew, vlmul: cand_lmul};
          vl_d      = new_vl;
          resp_vl_d = XLEN'(new_vl);
        end
      end
    end
  end

  // Architectural and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vtype_q   <= VtypeResetVal;
      vl_q      <= '0;
      rd_q      <= 5'd0;
      resp_vl_q <= '0;
      ill_q     <= 1'b0;
    end else begin
      vtype_q   <= vtype_d;
      vl_q      <= vl_d;
      rd_q      <= rd_d;
      resp_vl_q <= resp_vl_d;
      ill_q     <= ill_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vcfg_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vcfg_unit
// Brief    : Directed self-checking bench for vcfg_unit (VLEN=128, ELEN=64,
//            XLEN=32) with hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_vcfg_unit;
  import rvv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_vl;
  logic        resp_illegal;
  vtype_t      vtype;
  logic [7:0]  vl;

  int n_checks = 0;
  int n_fail   = 0;

  vcfg_unit #(.VLEN(128), .ELEN(64), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .insn_valid_i   (insn_valid),
    .insn_ready_o   (insn_ready),
    .insn_i         (insn),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rd_o      (resp_rd),
    .resp_vl_o      (resp_vl),
    .resp_illegal_o (resp_illegal),
    .vtype_o        (vtype),
    .vl_o           (vl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1i,
                                              input logic [10:0] zimm);
    return {1'b0, zimm, rs1i, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                               input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1i,
                                             input logic [4:0] rs2i);
    return {7'b1000000, rs2i, rs1i, 3'b111, rd, 7'b1010111};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and hold it until it is taken (bounded).
  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited     = 0;
    insn       = w;
    rs1        = a;
    rs2        = b;
    insn_valid = 1'b1;
    while (!insn_ready && waited < 20) begin
      step();
      waited++;
    end
    check_eq("accept_ready", insn_ready, 1);
    step();
    insn_valid = 1'b0;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [4:0] e_rd, input logic [31:0] e_vl,
                             input logic e_ill, input logic [8:0] e_vtype, input logic [7:0] e_vlo);
    check_eq({tag, "_valid"},   resp_valid, 1);
    check_eq({tag, "_rd"},      resp_rd, e_rd);
    check_eq({tag, "_respvl"},  resp_vl, e_vl);
    check_eq({tag, "_illegal"}, resp_illegal, e_ill);
    check_eq({tag, "_vtype"},   vtype, e_vtype);
    check_eq({tag, "_vl"},      vl, e_vlo);
  endtask

  // Issue one instruction, wait for the response two edges later, consume it.
  task automatic run(input string tag, input logic [31:0] w, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] e_rd, input logic [31:0] e_vl,
                     input logic [8:0] e_vtype, input logic [7:0] e_vlo);
    send(w, a, b);
    step();
    expect_resp(tag, e_rd, e_vl, 1'b0, e_vtype, e_vlo);
    ack();
  endtask

  initial begin
    rst_n      = 1'b0;
    insn_valid = 1'b0;
    insn       = '0;
    rs1        = '0;
    rs2        = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Reset state.
    check_eq("rst_vtype", vtype, 9'h100);
    check_eq("rst_vl", vl, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_ready", insn_ready, 1);

    // vsetvli x5, x1(=100), e32 m2: VLMAX 8; check exact latency.
    send(enc_vsetvli(5'd5, 5'd1, 11'h011), 32'd100, 32'd0);
    check_eq("lat_valid_early", resp_valid, 0);
    check_eq("lat_vl_early", vl, 0);
    check_eq("lat_ready_calc", insn_ready, 0);
    step();
    expect_resp("e32m2", 5'd5, 32'd8, 1'b0, 9'h011, 8'd8);
    ack();

    // vsetivli uimm=3 e8 mf2: VLMAX 8 -> vl 3.
    run("ivli", enc_vsetivli(5'd2, 5'd3, 10'h007), 32'd0, 32'd0, 5'd2, 32'd3, 9'h007, 8'd3);
    // vsetvli x3, x0, e16 m8: vl = VLMAX = 64.
    run("e16m8", enc_vsetvli(5'd3, 5'd0, 11'h00B), 32'd0, 32'd0, 5'd3, 32'd64, 9'h00B, 8'd64);
    // vsetvl with reserved vlmul=100 -> vill.
    run("vlmul_rsvd", enc_vsetvl(5'd4, 5'd1, 5'd2), 32'd10, 32'h4, 5'd4, 32'd0, 9'h100, 8'd0);
    // vsetvl e8 m4, AVL 70 > VLMAX 64.
    run("vsetvl_ok", enc_vsetvl(5'd9, 5'd1, 5'd2), 32'd70, 32'h0C2, 5'd9, 32'd64, 9'h0C2, 8'd64);
    // vsetvli e64 mf2 with ELEN=64 -> vill.
    run("e64mf2", enc_vsetvli(5'd1, 5'd1, 11'h01F), 32'd4, 32'd0, 5'd1, 32'd0, 9'h100, 8'd0);
    // Reserved zimm bit 8 -> vill.
    run("zimm_rsvd", enc_vsetvli(5'd1, 5'd1, 11'h111), 32'd4, 32'd0, 5'd1, 32'd0, 9'h100, 8'd0);
    // vsetvl with rs2 top bit set -> vill.
    run("rs2_vill", enc_vsetvl(5'd1, 5'd1, 5'd2), 32'd4, 32'h8000_0011, 5'd1, 32'd0, 9'h100, 8'd0);

    // Keep-vl form: vl 8 under e32 m2, then e8 m1 keeps 8, e64 m1 goes vill.
    run("restore", enc_vsetvli(5'd5, 5'd1, 11'h011), 32'd100, 32'd0, 5'd5, 32'd8, 9'h011, 8'd8);
    run("keep_ok", enc_vsetvli(5'd0, 5'd0, 11'h000), 32'd0, 32'd0, 5'd0, 32'd8, 9'h000, 8'd8);
    run("keep_vill", enc_vsetvli(5'd0, 5'd0, 11'h018), 32'd0, 32'd0, 5'd0, 32'd0, 9'h100, 8'd0);
    run("keep_from_vill", enc_vsetvli(5'd0, 5'd0, 11'h000), 32'd0, 32'd0, 5'd0, 32'd0, 9'h100, 8'd0);

    // Backpressure: e8 m1 AVL 5, response held for 5 cycles with a second
    // instruction waiting, then accepted on the handshake cycle.
    send(enc_vsetvli(5'd6, 5'd1, 11'h000), 32'd5, 32'd0);
    step();
    insn       = enc_vsetivli(5'd7, 5'd31, 10'h000);
    rs1        = 32'd0;
    insn_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", resp_valid, 1);
      check_eq("bp_rd", resp_rd, 6);
      check_eq("bp_vl", resp_vl, 5);
      check_eq("bp_ready", insn_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check_eq("bp_ready_pass", insn_ready, 1);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    insn_valid = 1'b0;
    check_eq("b2b_calc_valid", resp_valid, 0);
    check_eq("b2b_calc_vl", vl, 5);
    step();
    expect_resp("b2b", 5'd7, 32'd16, 1'b0, 9'h000, 8'd16);
    ack();

    // Non-OPCFG vector instruction (vadd.vv): illegal, state unchanged.
    send({6'b000000, 1'b1, 5'd2, 5'd3, 3'b000, 5'd1, 7'b1010111}, 32'd9, 32'd0);
    step();
    check_eq("ill_valid", resp_valid, 1);
    check_eq("ill_flag", resp_illegal, 1);
    check_eq("ill_respvl", resp_vl, 0);
    check_eq("ill_vtype", vtype, 9'h000);
    check_eq("ill_vl", vl, 16);
    ack();

    // Reset while in CALC: nothing committed.
    send(enc_vsetvli(5'd5, 5'd1, 11'h011), 32'd100, 32'd0);
    rst_n = 1'b0;
    #2;
    check_eq("midrst_vtype", vtype, 9'h100);
    check_eq("midrst_vl", vl, 0);
    rst_n = 1'b1;
    step();
    check_eq("midrst_resp_valid", resp_valid, 0);
    check_eq("midrst_ready", insn_ready, 1);
    check_eq("midrst_vl_after", vl, 0);
    check_eq("midrst_vtype_after", vtype, 9'h100);
    check_eq("midrst_rd", resp_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
